ppu_oam_dma: RTL and testbench

//  Sprite DMA engine for the CPU-side $4014 register. On a CPU write of page P it stalls the CPU.
//  It copies the 256 bytes at CPU addresses P*256..P*256+255 into PPU OAM.

---
 rtl/nes_bus_pkg.sv | 30 +++
 rtl/ppu_oam_dma.sv | 153 +++++++++++++++
 tb/tb_ppu_oam_dma.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nes_bus_pkg.sv
// Shared NES bus definitions: sprite-DMA FSM states, PPU register selects and APU/IO addresses.
package nes_bus_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dma_state_t;

  localparam logic [2:0] PPU_PPUCTRL   = 3'h0;
  localparam logic [2:0] PPU_PPUMASK   = 3'h1;
  localparam logic [2:0] PPU_PPUSTATUS = 3'h2;
  localparam logic [2:0] PPU_OAMADDR   = 3'h3;
  localparam logic [2:0] PPU_OAMDATA   = 3'h4;
  localparam logic [2:0] PPU_PPUSCROLL = 3'h5;
  localparam logic [2:0] PPU_PPUADDR   = 3'h6;
  localparam logic [2:0] PPU_PPUDATA   = 3'h7;

  localparam logic [15:0] IO_OAMDMA = 16'h4014;
  localparam logic [15:0] IO_JOY1   = 16'h4016;
  localparam logic [15:0] IO_JOY2   = 16'h4017;

  // Source byte address: index sits below page with no carry into the page.
  function automatic logic [15:0] dma_src_addr(input logic [7:0] page, input logic [7:0] index);
    return {page, index};
  endfunction

endpackage

// File: rtl/ppu_oam_dma.sv
// Sprite DMA engine for the $4014 register: stalls the CPU and copies one 256-byte CPU page
// into PPU OAM as alternating read / OAMDATA-write CPU cycles.
module ppu_oam_dma
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR = IO_OAMDMA,
  parameter logic [2:0]  OAMDATA_SEL  = PPU_OAMDATA,
  parameter int          NUM_BYTES    = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_ce,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_data,
  input  logic [7:0]  mem_data_in,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  output logic        dma_rw,
  output logic [7:0]  dma_data_out,
  output logic        ppu_cs_n,
  output logic [2:0]  ppu_addr
);

  localparam logic [7:0] LAST_INDEX = 8'(NUM_BYTES - 1);

  dma_state_t  r_state;
  logic [7:0]  r_index;
  logic [7:0]  r_page;
  logic        r_parity;
  logic        r_active;
  logic [15:0] r_addr;
  logic        r_rw;
  logic [7:0]  r_data;
  logic        r_cs_n;
  logic [2:0]  r_ppu_addr;

  dma_state_t  w_state_nxt;
  logic [7:0]  w_index_nxt;
  logic [7:0]  w_page_nxt;
  logic        w_active_nxt;
  logic [15:0] w_addr_nxt;
  logic        w_rw_nxt;
  logic [7:0]  w_data_nxt;
  logic        w_cs_n_nxt;
  logic [2:0]  w_ppu_addr_nxt;
  logic        w_trigger;

  assign w_trigger = (cpu_addr == DMA_REG_ADDR) && (cpu_rw == 1'b0);

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    w_state_nxt    = r_state;
    w_index_nxt    = r_index;
    w_page_nxt     = r_page;
    w_active_nxt   = r_active;
    w_addr_nxt     = r_addr;
    w_rw_nxt       = r_rw;
    w_data_nxt     = r_data;
    w_cs_n_nxt     = r_cs_n;
    w_ppu_addr_nxt = r_ppu_addr;
    case (r_state)
      IDLE: begin
        if (w_trigger) begin
          w_page_nxt   = cpu_data;
          w_index_nxt  = 8'h00;
          w_active_nxt = 1'b1;
          w_state_nxt  = HALT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      HALT: begin
        // Odd parity now means the following cycle is even, so reads can start directly.
        if (r_parity) begin
          w_state_nxt = READ;
          w_addr_nxt  = dma_src_addr(r_page, r_index);
          w_rw_nxt    = 1'b1;
          w_cs_n_nxt  = 1'b1;
        end else begin
          w_state_nxt = ALIGN;
        end
      end
      ALIGN: begin
        w_state_nxt = READ;
        w_addr_nxt  = dma_src_addr(r_page, r_index);
        w_rw_nxt    = 1'b1;
        w_cs_n_nxt  = 1'b1;
      end
      READ: begin
        w_state_nxt    = WRITE;
        w_data_nxt     = mem_data_in;
        w_rw_nxt       = 1'b0;
        w_ppu_addr_nxt = OAMDATA_SEL;
        w_cs_n_nxt     = 1'b0;
      end
      WRITE: begin
        w_rw_nxt   = 1'b1;
        w_cs_n_nxt = 1'b1;
        if (r_index == LAST_INDEX) begin
          w_state_nxt  = IDLE;
          w_active_nxt = 1'b0;
          w_index_nxt  = 8'h00;
        end else begin
          w_state_nxt = READ;
          w_index_nxt = r_index + 8'd1;
          w_addr_nxt  = dma_src_addr(r_page, r_index + 8'd1);
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_active_nxt = 1'b0;
        w_rw_nxt     = 1'b1;
        w_cs_n_nxt   = 1'b1;
      end
    endcase
  end

  // State, counter, parity and output registers, advanced once per CPU cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_index    <= 8'h00;
      r_page     <= 8'h00;
      r_parity   <= 1'b0;
      r_active   <= 1'b0;
      r_addr     <= 16'h0000;
      r_rw       <= 1'b1;
      r_data     <= 8'h00;
      r_cs_n     <= 1'b1;
      r_ppu_addr <= 3'h0;
    end else if (cpu_ce) begin
      r_state    <= w_state_nxt;
      r_index    <= w_index_nxt;
      r_page     <= w_page_nxt;
      r_parity   <= ~r_parity;
      r_active   <= w_active_nxt;
      r_addr     <= w_addr_nxt;
      r_rw       <= w_rw_nxt;
      r_data     <= w_data_nxt;
      r_cs_n     <= w_cs_n_nxt;
      r_ppu_addr <= w_ppu_addr_nxt;
    end
  end

  assign dma_active   = r_active;
  assign dma_addr     = r_addr;
  assign dma_rw       = r_rw;
  assign dma_data_out = r_data;
  assign ppu_cs_n     = r_cs_n;
  assign ppu_addr     = r_ppu_addr;

endmodule

// File: tb/tb_ppu_oam_dma.sv
// Self-checking bench for ppu_oam_dma: CPU-cycle stimulus, RAM model, write scoreboard and a
// PPU-clock model that captures OAM writes on chip-select falling edges.
module tb_ppu_oam_dma;

  logic        clk;
  logic        rst_n;
  logic        cpu_ce;
  logic [15:0] cpu_addr;
  logic        cpu_rw;
  logic [7:0]  cpu_data;
  logic [7:0]  mem_data_in;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic        dma_rw;
  logic [7:0]  dma_data_out;
  logic        ppu_cs_n;
  logic [2:0]  ppu_addr;

  int tests;
  int fails;
  logic tb_parity;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;
  exp_t sb[$];

  logic [7:0] mem [0:65535];
  logic [7:0] oam [0:255];

  logic       ppu_clear;
  logic       ppu_prev_cs;
  int         ppu_falls;
  int         ppu_bad;
  logic [7:0] ppu_optr;

  ppu_oam_dma dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_ce       (cpu_ce),
    .cpu_addr     (cpu_addr),
    .cpu_rw       (cpu_rw),
    .cpu_data     (cpu_data),
    .mem_data_in  (mem_data_in),
    .dma_active   (dma_active),
    .dma_addr     (dma_addr),
    .dma_rw       (dma_rw),
    .dma_data_out (dma_data_out),
    .ppu_cs_n     (ppu_cs_n),
    .ppu_addr     (ppu_addr)
  );

  assign mem_data_in = mem[dma_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PPU model clocked at 3x the CPU cycle rate; one OAM write per cs falling edge.
  always @(negedge clk) begin
    if (ppu_clear) begin
      ppu_prev_cs <= 1'b1;
      ppu_falls   <= 0;
      ppu_bad     <= 0;
      ppu_optr    <= 8'h00;
    end else begin
      ppu_prev_cs <= ppu_cs_n;
      if (ppu_prev_cs && !ppu_cs_n) begin
        ppu_falls      <= ppu_falls + 1;
        oam[ppu_optr]  <= dma_data_out;
        ppu_optr       <= ppu_optr + 8'd1;
        if (dma_rw !== 1'b0 || ppu_addr !== 3'h4 || dma_active !== 1'b1) ppu_bad <= ppu_bad + 1;
      end
    end
  end

  function automatic logic [7:0] ram_init(input logic [15:0] a);
    return a[7:0] ^ 8'hA5 ^ (a[15:8] ^ 8'h02);
  endfunction

  // One CPU cycle: cpu_ce high for exactly one clk edge, then two idle clocks.
  task automatic cpu_tick();
    cpu_ce = 1'b1;
    @(negedge clk);
    cpu_ce = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tb_parity = ~tb_parity;
  endtask

  task automatic bus_idle();
    cpu_addr = 16'h0000;
    cpu_rw   = 1'b1;
    cpu_data = 8'h00;
  endtask

  task automatic align_parity(input logic want);
    if (tb_parity != want) cpu_tick();
  endtask

  task automatic run_transfer(input logic [7:0] page, input int inject_at, input int reset_at,
                              input bit trig_at_end, output int act_cycles, output int n_writes);
    exp_t        e;
    int          exp_len;
    int          guard;
    bit          aborted;
    logic [15:0] prev_addr;
    logic        prev_rw;
    logic        prev_cs_n;
    sb.delete();
    for (int i = 0; i < 256; i++) begin
      e.addr = {page, 8'(i)};
      e.data = ram_init(e.addr);
      sb.push_back(e);
    end
    exp_len   = (tb_parity == 1'b0) ? 513 : 514;
    cpu_addr  = 16'h4014;
    cpu_rw    = 1'b0;
    cpu_data  = page;
    cpu_tick();
    bus_idle();
    act_cycles = 0;
    n_writes   = 0;
    guard      = 0;
    aborted    = 1'b0;
    prev_addr  = dma_addr;
    prev_rw    = dma_rw;
    prev_cs_n  = ppu_cs_n;
    while (dma_active && guard < 1000) begin
      act_cycles++;
      guard++;
      if (ppu_cs_n == 1'b0) begin
        if (n_writes == reset_at) begin
          rst_n = 1'b0;
          #1;
          tests++;
          if ({dma_active, dma_addr, dma_rw, dma_data_out, ppu_cs_n, ppu_addr} !==
              {1'b0, 16'h0000, 1'b1, 8'h00, 1'b1, 3'h0}) begin
            fails++;
            $display("FAIL async_reset: got act=%b addr=%h rw=%b data=%h cs_n=%b sel=%h, want 0 0000 1 00 1 0",
                     dma_active, dma_addr, dma_rw, dma_data_out, ppu_cs_n, ppu_addr);
          end
          @(negedge clk);
          rst_n     = 1'b1;
          tb_parity = 1'b0;
          aborted   = 1'b1;
          break;
        end
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL extra_write: unexpected write #%0d data=%h", n_writes, dma_data_out);
        end else begin
          e = sb.pop_front();
          if ({prev_addr, prev_rw, prev_cs_n, dma_rw, ppu_addr, dma_data_out} !==
              {e.addr, 1'b1, 1'b1, 1'b0, 3'h4, e.data}) begin
            fails++;
            $display("FAIL write[%0d]: got rd_addr=%h rd_rw=%b rd_cs_n=%b wr_rw=%b sel=%h data=%h, want %h 1 1 0 4 %h",
                     n_writes, prev_addr, prev_rw, prev_cs_n, dma_rw, ppu_addr, dma_data_out, e.addr, e.data);
          end
        end
        if (n_writes == inject_at) begin
          cpu_addr = 16'h4014;
          cpu_rw   = 1'b0;
          cpu_data = 8'h07;
        end
        if (n_writes == 255 && trig_at_end) begin
          cpu_addr = 16'h4014;
          cpu_rw   = 1'b0;
          cpu_data = page + 8'd1;
        end
        n_writes++;
      end
      prev_addr = dma_addr;
      prev_rw   = dma_rw;
      prev_cs_n = ppu_cs_n;
      cpu_tick();
      bus_idle();
    end
    if (guard >= 1000) begin
      tests++;
      fails++;
      $display("FAIL timeout: dma_active still high after %0d cycles, want <= 514", guard);
    end
    if (!aborted) begin
      tests++;
      if (act_cycles != exp_len || n_writes != 256) begin
        fails++;
        $display("FAIL length: got active=%0d writes=%0d, want active=%0d writes=256",
                 act_cycles, n_writes, exp_len);
      end
    end
  endtask

  task automatic check_idle(input string name);
    tests++;
    if ({dma_active, dma_rw, ppu_cs_n} !== 3'b011) begin
      fails++;
      $display("FAIL %s: got act=%b rw=%b cs_n=%b, want 0 1 1", name, dma_active, dma_rw, ppu_cs_n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if ({dma_active, dma_addr, dma_rw, dma_data_out, ppu_cs_n, ppu_addr} !==
        {1'b0, 16'h0000, 1'b1, 8'h00, 1'b1, 3'h0}) begin
      fails++;
      $display("FAIL reset_values: got act=%b addr=%h rw=%b data=%h cs_n=%b sel=%h, want 0 0000 1 00 1 0",
               dma_active, dma_addr, dma_rw, dma_data_out, ppu_cs_n, ppu_addr);
    end
    rst_n     = 1'b1;
    tb_parity = 1'b0;
    cpu_tick();
    check_idle("idle_after_reset");
  endtask

  task automatic test_basic();
    int act;
    int nw;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    tb_parity = 1'b0;
    run_transfer(8'h02, -1, -1, 1'b0, act, nw);
    check_idle("basic_done");
  endtask

  task automatic test_align();
    int act;
    int nw;
    cpu_tick();
    align_parity(1'b1);
    run_transfer(8'h04, -1, -1, 1'b0, act, nw);
  endtask

  task automatic test_page_ff();
    int act;
    int nw;
    run_transfer(8'hFF, -1, -1, 1'b0, act, nw);
    check_idle("page_ff_done");
    tests++;
    if (dma_addr !== 16'hFFFF) begin
      fails++;
      $display("FAIL page_ff_last_addr: got %h, want ffff", dma_addr);
    end
  endtask

  task automatic test_retrigger_ignored();
    int act;
    int nw;
    align_parity(1'b0);
    run_transfer(8'h02, 100, -1, 1'b0, act, nw);
    check_idle("retrigger_done");
  endtask

  task automatic test_reset_mid();
    int act;
    int nw;
    run_transfer(8'h06, -1, 37, 1'b0, act, nw);
    tests++;
    if (nw != 37) begin
      fails++;
      $display("FAIL reset_point: got %0d writes before reset, want 37", nw);
    end
    cpu_tick();
    check_idle("idle_after_mid_reset");
    run_transfer(8'h06, -1, -1, 1'b0, act, nw);
  endtask

  task automatic test_back_to_back();
    int act;
    int nw;
    run_transfer(8'h01, -1, -1, 1'b1, act, nw);
    tests++;
    if (dma_active !== 1'b0) begin
      fails++;
      $display("FAIL trigger_at_end: got dma_active=%b, want 0", dma_active);
    end
    run_transfer(8'h05, -1, -1, 1'b0, act, nw);
  endtask

  task automatic test_ppu_oam();
    int act;
    int nw;
    int bad_bytes;
    ppu_clear = 1'b1;
    cpu_tick();
    ppu_clear = 1'b0;
    cpu_tick();
    run_transfer(8'h03, -1, -1, 1'b0, act, nw);
    cpu_tick();
    tests++;
    if (ppu_falls != 256 || ppu_bad != 0) begin
      fails++;
      $display("FAIL ppu_cs_edges: got falls=%0d bad=%0d, want 256 0", ppu_falls, ppu_bad);
    end
    bad_bytes = 0;
    for (int i = 0; i < 256; i++) begin
      if (oam[i] !== ram_init({8'h03, 8'(i)})) bad_bytes++;
    end
    tests++;
    if (bad_bytes != 0) begin
      fails++;
      $display("FAIL oam_contents: got %0d wrong bytes, want 0", bad_bytes);
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    tb_parity = 1'b0;
    ppu_clear = 1'b1;
    cpu_ce    = 1'b0;
    rst_n     = 1'b0;
    bus_idle();
    for (int a = 0; a < 65536; a++) mem[a] = ram_init(16'(a));
    @(negedge clk);
    test_reset();
    test_basic();
    test_align();
    test_page_ff();
    test_retrigger_ignored();
    test_reset_mid();
    test_back_to_back();
    test_ppu_oam();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
